// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player input controller.
// Holds the board geometry, the cell and winner codes used on the board bus
// shared with game_fsm and ai_agent, and the controller state type.
package player_input_ctrl_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_AI     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;

  // CONFIRM is the only encoding with bit 0 set, so decoding p_confirm from
  // it stays clean on every legal state transition.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CONFIRM = 2'b01,
    ST_WAIT    = 2'b10
  } state_e;

endpackage

// File: rtl/player_input_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser, debounce counter and rising-edge
// detector for one raw board button.
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-low
//   btn_raw  raw button level, asynchronous to clk
//   press    one-cycle pulse when the debounced level rises
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stableDly_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any return to agreement (a bounce) restarts it at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      stableDly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      stableDly_q <= stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Both terms are flops, so the pulse is a clean single cycle.
  assign press = stable_q & ~stableDly_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Player-side move source for game_fsm. Conditions the next/prev/select
// buttons, keeps a cursor that only rests on empty cells, and issues one
// p_confirm strobe per legal selection, then waits for game_fsm to take it.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   btn_next/prev   raw buttons moving the cursor forward/backward
//   btn_sel         raw button committing the move at the cursor
//   cell_position   board from game_fsm, cell i at [2i+1:2i]
//   winner          00 while the game is running
//   player_turn     1 when the player is to move
//   move_cnt        moves played so far, used to detect acceptance
//   p_tick          cursor cell index 0..8
//   p_confirm       one-cycle move strobe
//   move_rejected   one-cycle pulse: illegal select or accept timeout
//   busy            high while waiting for game_fsm to accept
module player_input_ctrl
  import player_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACCEPT_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_sel,
  input  logic [17:0] cell_position,
  input  logic [1:0]  winner,
  input  logic        player_turn,
  input  logic [3:0]  move_cnt,
  output logic [3:0]  p_tick,
  output logic        p_confirm,
  output logic        move_rejected,
  output logic        busy
);

  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

  logic          pressNext;
  logic          pressPrev;
  logic          pressSel;
  state_e        state_q;
  state_e        state_d;
  logic [3:0]    cursor_q;
  logic [3:0]    cursor_d;
  logic [3:0]    latchedCnt_q;
  logic [TW-1:0] timer_q;
  logic          rejected_q;
  logic          cursorEmpty;
  logic          selLegal;
  logic          accepted;
  logic          timedOut;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uNext (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .press(pressNext)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uPrev (
    .clk(clk), .rst(rst), .btn_raw(btn_prev), .press(pressPrev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSel (
    .clk(clk), .rst(rst), .btn_raw(btn_sel), .press(pressSel)
  );

  // Nearest empty cell walking away from 'from' (mod 9), never 'from'
  // itself; returns 'from' unchanged when no other cell is free.
  function automatic logic [3:0] findEmpty(input logic [3:0] from,
                                           input logic fwd,
                                           input logic [17:0] board);
    logic [3:0] result;
    logic       found;
    int         idx;
    result = from;
    found  = 1'b0;
    for (int k = 1; k < NUM_CELLS; k++) begin
      if (fwd) idx = (int'(from) + k) % NUM_CELLS;
      else     idx = (int'(from) + NUM_CELLS - k) % NUM_CELLS;
      if (!found && board[2*idx +: 2] == CELL_EMPTY) begin
        result = 4'(idx);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  // Acceptance is any sign game_fsm has moved on from our move.
  always_comb begin
    cursorEmpty = (cell_position[2*int'(cursor_q) +: 2] == CELL_EMPTY);
    selLegal    = player_turn && (winner == WIN_NONE) && cursorEmpty;
    accepted    = (move_cnt != latchedCnt_q) || !player_turn || (winner != WIN_NONE);
    timedOut    = (timer_q == TW'(ACCEPT_TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (pressSel && selLegal) state_d = ST_CONFIRM;
      ST_CONFIRM: state_d = ST_WAIT;
      ST_WAIT:    if (accepted || timedOut) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    p_confirm = (state_q == ST_CONFIRM);
    busy      = (state_q == ST_WAIT);
  end

  // Cursor only moves in IDLE. Select outranks next/prev, next and prev
  // together cancel, and with no button action an occupied cursor cell is
  // stepped forward to the next free one.
  always_comb begin
    cursor_d = cursor_q;
    if (state_q == ST_IDLE && !pressSel) begin
      if (pressNext && !pressPrev)      cursor_d = findEmpty(cursor_q, 1'b1, cell_position);
      else if (pressPrev && !pressNext) cursor_d = findEmpty(cursor_q, 1'b0, cell_position);
      else if (!cursorEmpty)            cursor_d = findEmpty(cursor_q, 1'b1, cell_position);
    end
  end

  // Datapath: cursor, move-count snapshot, accept timer and reject pulse.
  // An accept in the same cycle as the timeout counts as accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_q     <= 4'd0;
      latchedCnt_q <= 4'd0;
      timer_q      <= '0;
      rejected_q   <= 1'b0;
    end else begin
      cursor_q <= cursor_d;
      if (state_q == ST_IDLE && pressSel && selLegal) latchedCnt_q <= move_cnt;
      if (state_q == ST_WAIT) timer_q <= timer_q + TW'(1);
      else                    timer_q <= '0;
      rejected_q <= (state_q == ST_IDLE && pressSel && !selLegal) ||
                    (state_q == ST_WAIT && !accepted && timedOut);
    end
  end

  assign p_tick        = cursor_q;
  assign move_rejected = rejected_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with a 4-cycle debounce and a
// minimal game_fsm stand-in that accepts a confirmed move 3 cycles later.
module tb_player_input_ctrl;
  import player_input_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_sel;
  logic [17:0] cell_position;
  logic [1:0]  winner;
  logic        player_turn;
  logic [3:0]  move_cnt = 4'd3;
  logic [3:0]  p_tick;
  logic        p_confirm;
  logic        move_rejected;
  logic        busy;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          confirmCount = 0;
  int          rejectCount = 0;
  int          busyCount = 0;
  logic [3:0]  lastConfirmTick = 4'd0;
  int          acceptDelay = 0;
  logic        acceptEnable = 1'b0;

  always #5 clk = ~clk;

  player_input_ctrl #(.DEBOUNCE_CYCLES(4), .ACCEPT_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_sel(btn_sel),
    .cell_position(cell_position), .winner(winner),
    .player_turn(player_turn), .move_cnt(move_cnt),
    .p_tick(p_tick), .p_confirm(p_confirm),
    .move_rejected(move_rejected), .busy(busy)
  );

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (p_confirm) begin
        confirmCount++;
        lastConfirmTick = p_tick;
      end
      if (move_rejected) rejectCount++;
      if (busy) busyCount++;
    end
  end

  // game_fsm stand-in: bumps move_cnt three cycles after a confirm.
  always @(negedge clk) begin
    if (acceptDelay > 0) begin
      acceptDelay--;
      if (acceptDelay == 0) move_cnt = move_cnt + 4'd1;
    end else if (rst === 1'b1 && acceptEnable && p_confirm) begin
      acceptDelay = 3;
    end
  end

  // mask = {sel, prev, next}; hold, then release long enough to settle.
  task automatic applyStimulus(input logic [2:0] mask, input int holdCycles);
    {btn_sel, btn_prev, btn_next} = mask;
    repeat (holdCycles) @(posedge clk);
    #1;
    {btn_sel, btn_prev, btn_next} = 3'b000;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    {btn_sel, btn_prev, btn_next} = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic earlyMove;
    rst = 1'b0;
    cell_position = 18'h0;
    winner = WIN_NONE;
    player_turn = 1'b0;
    {btn_sel, btn_prev, btn_next} = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      btn_next = i[0];
      btn_sel  = ~i[0];
      btn_prev = i[1];
    end
    testsRun++;
    if (p_tick !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_tick: got %0d want 0", p_tick); end
    testsRun++;
    if (p_confirm !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_confirm: got %b want 0", p_confirm); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testsRun++;
    if (move_rejected !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rejected: got %b want 0", move_rejected); end
    btn_sel = 1'b0;
    btn_prev = 1'b0;
    btn_next = 1'b1;
    @(negedge clk) rst = 1'b1;
    earlyMove = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (p_tick !== 4'd0) earlyMove = 1'b1;
    end
    testsRun++;
    if (earlyMove !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_early_press: cursor moved %0d within 6 cycles want 0", p_tick); end
    @(posedge clk);
    #1;
    testsRun++;
    if (p_tick !== 4'd1) begin testsFailed++; $display("[TB] FAIL reset_first_press: got %0d want 1", p_tick); end
    btn_next = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_bounce();
    cell_position = 18'h0;
    doReset();
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      @(posedge clk);
      #1;
    end
    testsRun++;
    if (p_tick !== 4'd0) begin testsFailed++; $display("[TB] FAIL bounce_during: got %0d want 0", p_tick); end
    btn_next = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    testsRun++;
    if (p_tick !== 4'd1) begin testsFailed++; $display("[TB] FAIL bounce_settled: got %0d want 1", p_tick); end
    btn_next = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    testsRun++;
    if (p_tick !== 4'd1) begin testsFailed++; $display("[TB] FAIL bounce_single: got %0d want 1", p_tick); end
  endtask

  task automatic test_skip_wrap();
    int r0;
    cell_position = 18'h20014;
    player_turn = 1'b0;
    doReset();
    applyStimulus(3'b001, 8);
    testsRun++;
    if (p_tick !== 4'd3) begin testsFailed++; $display("[TB] FAIL skip_next1: got %0d want 3", p_tick); end
    applyStimulus(3'b001, 8);
    testsRun++;
    if (p_tick !== 4'd4) begin testsFailed++; $display("[TB] FAIL skip_next2: got %0d want 4", p_tick); end
    applyStimulus(3'b011, 8);
    testsRun++;
    if (p_tick !== 4'd4) begin testsFailed++; $display("[TB] FAIL next_prev_cancel: got %0d want 4", p_tick); end
    r0 = rejectCount;
    applyStimulus(3'b101, 8);
    testsRun++;
    if (p_tick !== 4'd4) begin testsFailed++; $display("[TB] FAIL sel_wins_cursor: got %0d want 4", p_tick); end
    testsRun++;
    if (rejectCount - r0 !== 1) begin testsFailed++; $display("[TB] FAIL sel_wins_reject: got %0d want 1", rejectCount - r0); end
    doReset();
    applyStimulus(3'b010, 8);
    testsRun++;
    if (p_tick !== 4'd7) begin testsFailed++; $display("[TB] FAIL wrap_prev: got %0d want 7", p_tick); end
    cell_position = 18'h11555;
    applyStimulus(3'b001, 8);
    testsRun++;
    if (p_tick !== 4'd7) begin testsFailed++; $display("[TB] FAIL no_other_empty: got %0d want 7", p_tick); end
    cell_position = 18'h15555;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (p_tick !== 4'd7) begin testsFailed++; $display("[TB] FAIL full_board_hold: got %0d want 7", p_tick); end
  endtask

  task automatic test_legal_select();
    int c0, b0, r0;
    cell_position = 18'h00055;
    player_turn = 1'b0;
    winner = WIN_NONE;
    doReset();
    testsRun++;
    if (p_tick !== 4'd4) begin testsFailed++; $display("[TB] FAIL autofix_after_reset: got %0d want 4", p_tick); end
    player_turn = 1'b1;
    acceptEnable = 1'b1;
    c0 = confirmCount;
    b0 = busyCount;
    r0 = rejectCount;
    applyStimulus(3'b100, 20);
    acceptEnable = 1'b0;
    testsRun++;
    if (confirmCount - c0 !== 1) begin testsFailed++; $display("[TB] FAIL legal_confirm_count: got %0d want 1", confirmCount - c0); end
    testsRun++;
    if (lastConfirmTick !== 4'd4) begin testsFailed++; $display("[TB] FAIL legal_confirm_tick: got %0d want 4", lastConfirmTick); end
    testsRun++;
    if (busyCount - b0 !== 3) begin testsFailed++; $display("[TB] FAIL legal_busy_cycles: got %0d want 3", busyCount - b0); end
    testsRun++;
    if (rejectCount - r0 !== 0) begin testsFailed++; $display("[TB] FAIL legal_no_reject: got %0d want 0", rejectCount - r0); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL legal_back_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_illegal_select();
    int c0, r0;
    player_turn = 1'b0;
    c0 = confirmCount;
    r0 = rejectCount;
    applyStimulus(3'b100, 8);
    testsRun++;
    if (rejectCount - r0 !== 1) begin testsFailed++; $display("[TB] FAIL illegal_turn_reject: got %0d want 1", rejectCount - r0); end
    testsRun++;
    if (confirmCount - c0 !== 0) begin testsFailed++; $display("[TB] FAIL illegal_turn_confirm: got %0d want 0", confirmCount - c0); end
    player_turn = 1'b1;
    winner = 2'b01;
    c0 = confirmCount;
    r0 = rejectCount;
    applyStimulus(3'b100, 8);
    testsRun++;
    if (rejectCount - r0 !== 1) begin testsFailed++; $display("[TB] FAIL illegal_winner_reject: got %0d want 1", rejectCount - r0); end
    testsRun++;
    if (confirmCount - c0 !== 0) begin testsFailed++; $display("[TB] FAIL illegal_winner_confirm: got %0d want 0", confirmCount - c0); end
    winner = WIN_NONE;
  endtask

  task automatic test_timeout_autofix();
    int c0, b0, r0;
    player_turn = 1'b1;
    winner = WIN_NONE;
    acceptEnable = 1'b0;
    c0 = confirmCount;
    b0 = busyCount;
    r0 = rejectCount;
    applyStimulus(3'b100, 8);
    repeat (70) @(posedge clk);
    #1;
    testsRun++;
    if (confirmCount - c0 !== 1) begin testsFailed++; $display("[TB] FAIL timeout_confirm: got %0d want 1", confirmCount - c0); end
    testsRun++;
    if (busyCount - b0 !== 64) begin testsFailed++; $display("[TB] FAIL timeout_busy_cycles: got %0d want 64", busyCount - b0); end
    testsRun++;
    if (rejectCount - r0 !== 1) begin testsFailed++; $display("[TB] FAIL timeout_reject: got %0d want 1", rejectCount - r0); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_idle: busy got %b want 0", busy); end
    cell_position = 18'h00055 | (18'(CELL_AI) << 8);
    @(negedge clk);
    testsRun++;
    if (p_tick !== 4'd4) begin testsFailed++; $display("[TB] FAIL autofix_before_edge: got %0d want 4", p_tick); end
    @(posedge clk);
    #1;
    testsRun++;
    if (p_tick !== 4'd5) begin testsFailed++; $display("[TB] FAIL autofix_ai_cell: got %0d want 5", p_tick); end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_bounce();
    test_skip_wrap();
    test_legal_select();
    test_illegal_select();
    test_timeout_autofix();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
